// File: rtl/packet_tx_pkg.sv
// Shared definitions for the packet transmitter: state encoding, CRC-8 constants,
// header field layout and the CRC-8 byte update. CRC support is enabled by PACKET_TX_CRC_EN.
package packet_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
`ifdef PACKET_TX_CRC_EN
        ST_CRC     = 3'd3,
`endif
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // Header byte: address in bits [1:0], length fills bits [7:2]
    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_ADDR_W   = 2;
    localparam int HDR_LEN_LSB  = 2;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/packet_tx_crc8_calc.sv
// Combinational CRC-8 (poly 0x07) single-byte update; only built when PACKET_TX_CRC_EN is defined.
`ifdef PACKET_TX_CRC_EN
module crc8_calc
    import packet_tx_pkg::*;
(
    input  logic [7:0] crc,
    input  logic [7:0] data,
    output logic [7:0] crc_next
);

    // Next CRC after folding in one byte
    always_comb begin
        crc_next = crc8_byte(crc, data);
    end

endmodule
`endif

// File: rtl/packet_tx.sv
// Packet transmitter: header, payload through a one-byte holding register, optional
// CRC-8 trailer (PACKET_TX_CRC_EN) towards a req/ack router input.
module packet_tx
    import packet_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_SIZE  = 6
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pkt_start,
    input  logic [1:0]            pkt_addr,
    input  logic [DATA_SIZE-1:0]  pkt_len,
    input  logic [DATA_WIDTH-1:0] pay_data,
    input  logic                  pay_valid,
    output logic                  pay_ready,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic                  data_in_req,
    input  logic                  data_in_ack,
    output logic                  busy,
    output logic                  pkt_done,
    output logic                  pkt_err
);

    state_t                state_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [DATA_WIDTH-1:0] hold_data_r;
    logic                  hold_full_r;
    logic                  req_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  err_r;
    logic [DATA_SIZE-1:0]  cnt_r;

    logic [DATA_WIDTH-1:0] hdr_s;
    logic [DATA_WIDTH-1:0] data_s;
    logic                  req_s;
    logic                  ready_s;
    logic                  xfer_s;
    logic                  take_s;
    logic                  last_s;
    logic                  hold_full_next_s;

`ifdef PACKET_TX_CRC_EN
    logic [7:0] crc_r;
    logic [7:0] crc_next_s;

    crc8_calc u_crc8_calc (
        .crc      (crc_r),
        .data     (data_s[7:0]),
        .crc_next (crc_next_s)
    );
`endif

    // Header byte assembled from the request fields
    always_comb begin
        hdr_s = '0;
        hdr_s[HDR_ADDR_LSB +: HDR_ADDR_W] = pkt_addr;
        hdr_s[HDR_LEN_LSB +: DATA_SIZE]   = pkt_len;
    end

    // Output selection and handshakes; an empty holding register passes the source byte straight through
    always_comb begin
        req_s   = req_r;
        data_s  = data_r;
        ready_s = 1'b0;
        if (state_r == ST_PAYLOAD) begin
            if (hold_full_r) begin
                req_s   = 1'b1;
                data_s  = hold_data_r;
                ready_s = data_in_ack && (cnt_r > DATA_SIZE'(1));
            end else begin
                req_s   = pay_valid && (cnt_r != '0);
                data_s  = pay_data;
                ready_s = (cnt_r != '0);
            end
        end else begin
            req_s   = req_r;
            data_s  = data_r;
            ready_s = 1'b0;
        end
        xfer_s = req_s && data_in_ack;
        take_s = pay_valid && ready_s;
        last_s = xfer_s && (cnt_r == DATA_SIZE'(1));
        if (hold_full_r) begin
            hold_full_next_s = xfer_s ? take_s : 1'b1;
        end else begin
            hold_full_next_s = take_s && !xfer_s;
        end
    end

    assign data_in     = data_s;
    assign data_in_req = req_s;
    assign pay_ready   = ready_s;
    assign busy        = busy_r;
    assign pkt_done    = done_r;
    assign pkt_err     = err_r;

    // Packet sequencing FSM; cnt_r counts payload bytes still to be sent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            data_r      <= '0;
            hold_data_r <= '0;
            hold_full_r <= 1'b0;
            req_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            cnt_r       <= '0;
`ifdef PACKET_TX_CRC_EN
            crc_r       <= CRC8_INIT;
`endif
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pkt_start) begin
                        if (pkt_len == '0) begin
                            err_r <= 1'b1;
                        end else begin
                            state_r     <= ST_HEADER;
                            data_r      <= hdr_s;
                            req_r       <= 1'b1;
                            busy_r      <= 1'b1;
                            cnt_r       <= pkt_len;
                            hold_full_r <= 1'b0;
`ifdef PACKET_TX_CRC_EN
                            crc_r       <= CRC8_INIT;
`endif
                        end
                    end
                end
                ST_HEADER: begin
                    if (xfer_s) begin
                        state_r <= ST_PAYLOAD;
                        req_r   <= 1'b0;
`ifdef PACKET_TX_CRC_EN
                        crc_r   <= crc_next_s;
`endif
                    end
                end
                ST_PAYLOAD: begin
                    hold_full_r <= hold_full_next_s;
                    if (take_s) begin
                        hold_data_r <= pay_data;
                    end
                    if (xfer_s) begin
                        cnt_r <= cnt_r - DATA_SIZE'(1);
`ifdef PACKET_TX_CRC_EN
                        crc_r <= crc_next_s;
`endif
                    end
                    if (last_s) begin
                        hold_full_r <= 1'b0;
`ifdef PACKET_TX_CRC_EN
                        state_r <= ST_CRC;
                        data_r  <= DATA_WIDTH'(crc_next_s);
                        req_r   <= 1'b1;
`else
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
`endif
                    end
                end
`ifdef PACKET_TX_CRC_EN
                ST_CRC: begin
                    if (xfer_s) begin
                        state_r <= ST_DONE;
                        req_r   <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    req_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_packet_tx.sv
// Directed, table-driven bench for packet_tx; expectations follow PACKET_TX_CRC_EN when defined.
module tb_packet_tx;

    logic       clk;
    logic       rst_n;
    logic       pkt_start;
    logic [1:0] pkt_addr;
    logic [5:0] pkt_len;
    logic [7:0] pay_data;
    logic       pay_valid;
    logic       pay_ready;
    logic [7:0] data_in;
    logic       data_in_req;
    logic       data_in_ack;
    logic       busy;
    logic       pkt_done;
    logic       pkt_err;

    int n_checks = 0;
    int n_fail   = 0;

    packet_tx #(.DATA_WIDTH(8), .DATA_SIZE(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pkt_start   (pkt_start),
        .pkt_addr    (pkt_addr),
        .pkt_len     (pkt_len),
        .pay_data    (pay_data),
        .pay_valid   (pay_valid),
        .pay_ready   (pay_ready),
        .data_in     (data_in),
        .data_in_req (data_in_req),
        .data_in_ack (data_in_ack),
        .busy        (busy),
        .pkt_done    (pkt_done),
        .pkt_err     (pkt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [1:0] addr;
        logic [5:0] len;
        logic [7:0] pdata;
        logic       pvalid;
        logic       ack;
        logic       req;
        logic [7:0] data;
        logic       ready;
        logic       busy;
        logic       done;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic start, input logic [1:0] addr, input logic [5:0] len,
                                input logic [7:0] pdata, input logic pvalid, input logic ack,
                                input logic req, input logic [7:0] data, input logic ready,
                                input logic bsy, input logic done, input logic err);
        vec_t v;
        v.start = start; v.addr = addr; v.len = len; v.pdata = pdata; v.pvalid = pvalid;
        v.ack = ack; v.req = req; v.data = data; v.ready = ready; v.busy = bsy;
        v.done = done; v.err = err;
        return v;
    endfunction

    // Bit-serial reference CRC-8, poly 0x07
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int b = 7; b >= 0; b--) begin
            fb = r[7] ^ d[b];
            r  = {r[6:0], 1'b0};
            if (fb) r = r ^ 8'h07;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp_v);
        end
    endtask

    task automatic idle_inputs();
        pkt_start = 1'b0; pkt_addr = 2'd0; pkt_len = 6'd0;
        pay_data = 8'h00; pay_valid = 1'b0; data_in_ack = 1'b0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        pkt_start = v.start; pkt_addr = v.addr; pkt_len = v.len;
        pay_data = v.pdata; pay_valid = v.pvalid; data_in_ack = v.ack;
        #1;
        chk({tag, ".req"},   {7'd0, data_in_req}, {7'd0, v.req});
        if (v.req) chk({tag, ".data"}, data_in, v.data);
        chk({tag, ".ready"}, {7'd0, pay_ready},   {7'd0, v.ready});
        chk({tag, ".busy"},  {7'd0, busy},        {7'd0, v.busy});
        chk({tag, ".done"},  {7'd0, pkt_done},    {7'd0, v.done});
        chk({tag, ".err"},   {7'd0, pkt_err},     {7'd0, v.err});
    endtask

    task automatic apply_range(input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            apply(tbl[i], $sformatf("%s[%0d]", tag, i - lo));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "time limit");
    end

    initial begin
        int b_lo, b_hi, r_lo, r_hi;
        logic [7:0] c;

        // Basic packet: addr=1, len=1, payload 0x00, ack held high
        b_lo = tbl.size();
        tbl.push_back(mk(1'b1, 2'd1, 6'd1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 6'd0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 6'd0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0));
`ifdef PACKET_TX_CRC_EN
        tbl.push_back(mk(1'b0, 2'd0, 6'd0, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h41, 1'b0, 1'b1, 1'b0, 1'b0));
`endif
        tbl.push_back(mk(1'b0, 2'd0, 6'd0, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        b_hi = tbl.size() - 1;

        // Zero-length reject, then a packet with pkt_start pulses while busy
        r_lo = tbl.size();
        tbl.push_back(mk(1'b1, 2'd2, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 2'd2, 6'd2, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 2'd3, 6'd5, 8'h00, 1'b0, 1'b1, 1'b1, 8'h0A, 1'b0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 2'd0, 6'd0, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 6'd0, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0));
`ifdef PACKET_TX_CRC_EN
        c = crc_step(crc_step(crc_step(8'h00, 8'h0A), 8'hA5), 8'h3C);
        tbl.push_back(mk(1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1, c, 1'b0, 1'b1, 1'b0, 1'b0));
`endif
        tbl.push_back(mk(1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0));
        r_hi = tbl.size() - 1;

        // Reset state, with request-like inputs present
        rst_n = 1'b0;
        idle_inputs();
        apply(mk(1'b1, 2'd1, 6'd1, 8'h77, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), "rst");
        chk("rst.data", data_in, 8'h00);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        apply_range(b_lo, b_hi, "basic");
        apply_range(r_lo, r_hi, "reject");

        // Header held for 5 cycles by a low ack
        apply(mk(1'b1, 2'd1, 6'd1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), "stall.start");
        for (int k = 0; k < 5; k++) begin
            apply(mk(1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0), $sformatf("stall.hold%0d", k));
        end
        apply(mk(1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0), "stall.ack");
        apply(mk(1'b0, 2'd0, 6'd0, 8'hE7, 1'b1, 1'b1, 1'b1, 8'hE7, 1'b1, 1'b1, 1'b0, 1'b0), "stall.pay");
`ifdef PACKET_TX_CRC_EN
        apply(mk(1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1, crc_step(crc_step(8'h00, 8'h05), 8'hE7),
                 1'b0, 1'b1, 1'b0, 1'b0), "stall.crc");
`endif
        apply(mk(1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0), "stall.done");

        // len=3 with two-cycle gaps in pay_valid
        apply(mk(1'b1, 2'd0, 6'd3, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), "gap.start");
        apply(mk(1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h0C, 1'b0, 1'b1, 1'b0, 1'b0), "gap.hdr");
        apply(mk(1'b0, 2'd0, 6'd0, 8'h11, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0), "gap.b0");
        apply(mk(1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0), "gap.g0");
        apply(mk(1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0), "gap.g1");
        apply(mk(1'b0, 2'd0, 6'd0, 8'h22, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0), "gap.b1");
        apply(mk(1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0), "gap.g2");
        apply(mk(1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0), "gap.g3");
        apply(mk(1'b0, 2'd0, 6'd0, 8'h33, 1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0), "gap.b2");
`ifdef PACKET_TX_CRC_EN
        c = crc_step(crc_step(crc_step(crc_step(8'h00, 8'h0C), 8'h11), 8'h22), 8'h33);
        apply(mk(1'b0, 2'd0, 6'd0, 8'h44, 1'b1, 1'b1, 1'b1, c, 1'b0, 1'b1, 1'b0, 1'b0), "gap.crc");
`endif
        apply(mk(1'b0, 2'd0, 6'd0, 8'h44, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0), "gap.done");
        apply(mk(1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), "gap.idle");

        // Reset while a payload byte sits in the holding register
        apply(mk(1'b1, 2'd3, 6'd2, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), "mrst.start");
        apply(mk(1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h0B, 1'b0, 1'b1, 1'b0, 1'b0), "mrst.hdr");
        apply(mk(1'b0, 2'd0, 6'd0, 8'h55, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0), "mrst.pay");
        @(negedge clk);
        pay_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst.req_async", {7'd0, data_in_req}, 8'h00);
        chk("mrst.busy_async", {7'd0, busy}, 8'h00);
        for (int k = 0; k < 2; k++) begin
            apply(mk(1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), $sformatf("mrst.in%0d", k));
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        apply(mk(1'b0, 2'd0, 6'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0), "mrst.after");
        apply_range(b_lo, b_hi, "mrst.basic");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
